test_pattern_gen: RTL and testbench

Parametrised successor to the fixed SVGA colour-bar source. Sits after vga_sync in the pixel clock domain. Consumes blanking and sync, tracks its own active-area x/y position, and drives registered RGB in one of four runtime-selectable patterns. Sync outputs are delayed so they stay aligned with RGB.

---
 rtl/test_pattern_gen_if.sv | 27 ++
 rtl/test_pattern_gen.sv | 192 +++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_pattern_gen_if.sv
// Video bus between the timing source and test_pattern_gen.
// No handshake: every signal is sampled on each clk_pixel edge; outputs lag inputs by one cycle.
interface test_pattern_gen_if #(
    parameter int COLOR_BITS = 4
) ();
    logic                  hblank;
    logic                  vblank;
    logic                  hsync_in;
    logic                  vsync_in;
    logic [1:0]            mode;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] green;
    logic [COLOR_BITS-1:0] blue;
    logic                  hsync;
    logic                  vsync;
    logic                  frame_start;

    modport master (
        output hblank, vblank, hsync_in, vsync_in, mode,
        input  red, green, blue, hsync, vsync, frame_start
    );

    modport slave (
        input  hblank, vblank, hsync_in, vsync_in, mode,
        output red, green, blue, hsync, vsync, frame_start
    );
endinterface

// File: rtl/test_pattern_gen.sv
// Runtime-selectable test pattern source (bars, gray ramp, checker, grid) with 1-cycle aligned syncs.
// Optional macro PATTERN_SCROLL_EN adds a per-frame horizontal scroll for modes 1-3.
module test_pattern_gen #(
    parameter int COLOR_BITS = 4,
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int NUM_BARS   = 7,
    parameter int BAR_WIDTH  = 115,
    parameter int BAR_LEVEL  = 11,
    parameter int RAMP_SHIFT = 6,
    parameter int CHECK_LOG2 = 5,
    parameter int GRID_LOG2  = 6
) (
    input  logic               clk_pixel,
    input  logic               rst_n,
    test_pattern_gen_if.slave  vif
);

    localparam int XW  = $clog2(H_ACTIVE);
    localparam int YW  = $clog2(V_ACTIVE);
    localparam int BCW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    localparam logic [XW-1:0]         X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]         Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BCW-1:0]        BC_LAST  = BCW'(BAR_WIDTH - 1);
    localparam logic [2:0]            BAR_LAST = 3'(NUM_BARS - 1);
    localparam logic [XW-1:0]         RAMP_MAX = XW'((2 ** COLOR_BITS) - 1);
    localparam logic [COLOR_BITS-1:0] FULL     = {COLOR_BITS{1'b1}};
    localparam logic [COLOR_BITS-1:0] LEVEL    = COLOR_BITS'(BAR_LEVEL);

    logic                  in_display;
    logic                  fs_now;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic                  disp_q, disp_d;
    logic [BCW-1:0]        bar_cnt_q, bar_cnt_d;
    logic [2:0]            bar_q, bar_d;
    logic                  vblank_q, vblank_d;
    logic [1:0]            mode_q, mode_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] green_q, green_d;
    logic [COLOR_BITS-1:0] blue_q, blue_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  frame_start_q, frame_start_d;
    logic [XW-1:0]         xs;
    logic [XW-1:0]         ramp_raw;
    logic [COLOR_BITS-1:0] ramp;
    logic                  checker_on;
    logic                  grid_on;

    assign in_display = ~(vif.hblank | vif.vblank);
    assign fs_now     = in_display && (x_q == '0) && (y_q == '0);

    // Position, bar tracking, mode capture and sync delay.
    always_comb begin
        x_d = x_q;
        if (vif.hblank) begin
            x_d = '0;
        end else if (in_display && (x_q != X_LAST)) begin
            x_d = x_q + 1'b1;
        end

        y_d = y_q;
        if (vif.vblank) begin
            y_d = '0;
        end else if (disp_q && !in_display && (y_q != Y_LAST)) begin
            y_d = y_q + 1'b1;
        end

        bar_cnt_d = '0;
        bar_d     = '0;
        if (in_display) begin
            if (bar_cnt_q == BC_LAST) begin
                bar_cnt_d = '0;
                bar_d     = (bar_q == BAR_LAST) ? bar_q : bar_q + 1'b1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
                bar_d     = bar_q;
            end
        end

        disp_d        = in_display;
        vblank_d      = vif.vblank;
        mode_d        = (vif.vblank && !vblank_q) ? vif.mode : mode_q;
        hsync_d       = vif.hsync_in;
        vsync_d       = vif.vsync_in;
        frame_start_d = fs_now;
    end

`ifdef PATTERN_SCROLL_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // The first pixel already sees the new count, so a whole frame shares one offset.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {7'd0, fs_now};
        xs          = x_q + XW'(frame_cnt_d);
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    always_comb begin
        xs = x_q;
    end
`endif

    always_comb begin
        ramp_raw   = xs >> RAMP_SHIFT;
        ramp       = (ramp_raw > RAMP_MAX) ? FULL : ramp_raw[COLOR_BITS-1:0];
        checker_on = xs[CHECK_LOG2] ^ y_q[CHECK_LOG2];
        grid_on    = (xs[GRID_LOG2-1:0] == '0) || (y_q[GRID_LOG2-1:0] == '0) ||
                     (xs == X_LAST) || (y_q == Y_LAST);
    end

    // Bar index bits map straight to channels: R off for 2,3,6,7; G off for 4..7; B off for odd.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_display) begin
            case (mode_q)
                2'd0: begin
                    red_d   = bar_q[1] ? '0 : LEVEL;
                    green_d = bar_q[2] ? '0 : LEVEL;
                    blue_d  = bar_q[0] ? '0 : LEVEL;
                end
                2'd1: begin
                    red_d   = ramp;
                    green_d = ramp;
                    blue_d  = ramp;
                end
                2'd2: begin
                    red_d   = checker_on ? FULL : '0;
                    green_d = checker_on ? FULL : '0;
                    blue_d  = checker_on ? FULL : '0;
                end
                default: begin
                    red_d   = grid_on ? FULL : '0;
                    green_d = grid_on ? FULL : '0;
                    blue_d  = grid_on ? FULL : '0;
                end
            endcase
        end
    end

    // vblank_q resets high so a reset taken inside vblank is not seen as a vblank rise.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            disp_q        <= 1'b0;
            bar_cnt_q     <= '0;
            bar_q         <= '0;
            vblank_q      <= 1'b1;
            mode_q        <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            disp_q        <= disp_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_q         <= bar_d;
            vblank_q      <= vblank_d;
            mode_q        <= mode_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.red         = red_q;
    assign vif.green       = green_q;
    assign vif.blue        = blue_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: frame-level stimulus, per-cycle scoreboard, spot-value table.
module tb_test_pattern_gen;

    localparam int CB = 4;
    localparam int H  = 800;
    localparam int V  = 40;
    localparam int NB = 7;
    localparam int BW = 115;
    localparam int BL = 11;
    localparam int RS = 6;
    localparam int CL = 5;
    localparam int GL = 6;
    localparam int XW = $clog2(H);

    // ---------------- clock / reset ----------------
    logic clk_pixel = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    test_pattern_gen_if #(.COLOR_BITS(CB)) vif ();

    test_pattern_gen #(
        .COLOR_BITS(CB), .H_ACTIVE(H), .V_ACTIVE(V), .NUM_BARS(NB), .BAR_WIDTH(BW),
        .BAR_LEVEL(BL), .RAMP_SHIFT(RS), .CHECK_LOG2(CL), .GRID_LOG2(GL)
    ) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .vif       (vif)
    );

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    logic [14:0] exp_q[$];
    int          tag_q[$];
    logic [11:0] cap[int];
    int          m_mode;
    bit          m_prev_vb;
    int          m_fcnt;
    int          fid;

    typedef struct {
        int          f;
        int          px;
        int          ln;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[$];

    function automatic int key_of(input int f, input int px, input int ln);
        return f * 100000 + ln * 1000 + px;
    endfunction

    function automatic logic [11:0] model_rgb(input int md, input int px, input int ln, input int fc);
        int x, y, xs, bar, g;
        logic [3:0] l, f;
        l = 4'(BL);
        f = 4'hF;
        x = (px > H - 1) ? H - 1 : px;
        y = (ln > V - 1) ? V - 1 : ln;
        xs = (x + fc) % (1 << XW);
        model_rgb = 12'h000;
        case (md)
            0: begin
                bar = px / BW;
                if (bar > NB - 1) bar = NB - 1;
                case (bar)
                    0: model_rgb = {l, l, l};
                    1: model_rgb = {l, l, 4'h0};
                    2: model_rgb = {4'h0, l, l};
                    3: model_rgb = {4'h0, l, 4'h0};
                    4: model_rgb = {l, 4'h0, l};
                    5: model_rgb = {l, 4'h0, 4'h0};
                    6: model_rgb = {4'h0, 4'h0, l};
                    default: model_rgb = 12'h000;
                endcase
            end
            1: begin
                g = xs >> RS;
                if (g > (1 << CB) - 1) g = (1 << CB) - 1;
                model_rgb = {4'(g), 4'(g), 4'(g)};
            end
            2: if ((((xs >> CL) ^ (y >> CL)) & 1) == 1) model_rgb = {f, f, f};
            3: if ((xs % (1 << GL)) == 0 || (y % (1 << GL)) == 0 || xs == H - 1 || y == V - 1)
                   model_rgb = {f, f, f};
            default: model_rgb = 12'h000;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input bit hb, input bit vb, input bit hs, input bit vs, input int px, input int ln);
        bit disp, fs;
        int fc;
        logic [11:0] rgb;
        vif.hblank   = hb;
        vif.vblank   = vb;
        vif.hsync_in = hs;
        vif.vsync_in = vs;
        disp = !hb && !vb;
        fs   = disp && px == 0 && ln == 0;
        fc   = m_fcnt + (fs ? 1 : 0);
`ifdef PATTERN_SCROLL_EN
        m_fcnt = fc % 256;
`else
        fc = 0;
`endif
        rgb = disp ? model_rgb(m_mode, px, ln, fc) : 12'h000;
        if (chk_en) begin
            exp_q.push_back({rgb, hs, vs, fs});
            tag_q.push_back(disp ? key_of(fid, px, ln) : -1);
        end
        if (vb && !m_prev_vb) m_mode = int'(vif.mode);
        m_prev_vb = vb;
        @(posedge clk_pixel);
        #2;
    endtask

    task automatic drive_line(input int len, input int ln, input bit vb, input bit vs);
        for (int px = 0; px < len; px++) step(1'b0, vb, 1'b0, vs, px, ln);
        for (int i = 0; i < 16; i++) step(1'b1, vb, (i >= 4 && i < 12), vs, 0, ln);
    endtask

    task automatic drive_vblank(input int n);
        for (int l = 0; l < n; l++) drive_line(72, 0, 1'b1, l == 0);
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic add_vec(input int f, input int px, input int ln, input logic [11:0] rgb);
        vec_t v;
        v.f = f; v.px = px; v.ln = ln; v.rgb = rgb;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_prev_vb = 1'b1;
        m_fcnt    = 0;
    endtask

    // ---------------- monitor: pops one expectation per cycle ----------------
    logic [14:0] mon_act, mon_exp;
    int          mon_key;
    always @(posedge clk_pixel) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_key = tag_q.pop_front();
            mon_act = {vif.red, vif.green, vif.blue, vif.hsync, vif.vsync, vif.frame_start};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL scoreboard key=%0d act=%h exp=%h", mon_key, mon_act, mon_exp);
            end
            if (mon_key >= 0) cap[mon_key] = mon_act[14:3];
        end
    end

    // ---------------- test ----------------
    initial begin
        // Spot values {frame, x, line, rgb}; B = 11 is the bar level.
        add_vec(1, 0,   0, 12'hBBB);
        add_vec(1, 114, 0, 12'hBBB);
        add_vec(1, 115, 0, 12'hBB0);
        add_vec(1, 229, 1, 12'hBB0);
        add_vec(1, 230, 0, 12'h0BB);
        add_vec(1, 689, 0, 12'hB00);
        add_vec(1, 690, 0, 12'h00B);
        add_vec(1, 799, 1, 12'h00B);
        add_vec(6, 0,   0, 12'hBBB);
        add_vec(6, 690, 0, 12'h00B);
`ifdef PATTERN_SCROLL_EN
        add_vec(2, 0,   0, 12'h000);
        add_vec(2, 61,  0, 12'h000);
        add_vec(2, 62,  0, 12'h111);
        add_vec(3, 28,  0, 12'h000);
        add_vec(3, 29,  0, 12'hFFF);
        add_vec(4, 60,  5, 12'hFFF);
        add_vec(4, 0,   5, 12'h000);
        add_vec(4, 795, 1, 12'hFFF);
`else
        add_vec(2, 0,   0, 12'h000);
        add_vec(2, 63,  0, 12'h000);
        add_vec(2, 64,  0, 12'h111);
        add_vec(2, 799, 0, 12'hCCC);
        add_vec(3, 0,   0, 12'h000);
        add_vec(3, 32,  0, 12'hFFF);
        add_vec(3, 32, 32, 12'h000);
        add_vec(3, 0,  32, 12'hFFF);
        add_vec(3, 31, 31, 12'h000);
        add_vec(4, 0,   5, 12'hFFF);
        add_vec(4, 64,  5, 12'hFFF);
        add_vec(4, 128, 1, 12'hFFF);
        add_vec(4, 1,   1, 12'h000);
        add_vec(4, 799, 1, 12'hFFF);
        add_vec(4, 805, 2, 12'hFFF);
        add_vec(4, 65,  3, 12'h000);
        add_vec(4, 10, 25, 12'h000);
        add_vec(4, 33,  0, 12'hFFF);
        add_vec(4, 10, 39, 12'hFFF);
        add_vec(4, 10, 40, 12'hFFF);
`endif

        vif.hblank = 1'b1; vif.vblank = 1'b1; vif.hsync_in = 1'b0; vif.vsync_in = 1'b0; vif.mode = 2'd0;
        fid = 0;
        model_reset();
        repeat (3) @(posedge clk_pixel);
        #2;
        check_val("rst_red", int'(vif.red), 0);
        check_val("rst_green", int'(vif.green), 0);
        check_val("rst_blue", int'(vif.blue), 0);
        check_val("rst_hsync", int'(vif.hsync), 0);
        check_val("rst_vsync", int'(vif.vsync), 0);
        check_val("rst_frame_start", int'(vif.frame_start), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        drive_vblank(2);
        fid = 1;                                   // mode 0 bars
        drive_line(800, 0, 1'b0, 1'b0);
        drive_line(800, 1, 1'b0, 1'b0);
        vif.mode = 2'd1;
        drive_vblank(2);
        fid = 2;                                   // mode 1 ramp
        drive_line(800, 0, 1'b0, 1'b0);
        vif.mode = 2'd2;
        drive_vblank(2);
        fid = 3;                                   // mode 2 checker
        for (int ln = 0; ln < 34; ln++) drive_line(72, ln, 1'b0, 1'b0);
        vif.mode = 2'd3;
        drive_vblank(2);
        fid = 4;                                   // mode 3 grid, overrun line, y saturation
        for (int ln = 0; ln < 41; ln++) begin
            if (ln == 20) vif.mode = 2'd0;         // must not apply until next vblank rise
            drive_line((ln < 2) ? 800 : ((ln == 2) ? 810 : 72), ln, 1'b0, 1'b0);
        end
        drive_vblank(2);

        fid = 5;                                   // mode 0, reset mid-line
        for (int px = 0; px < 300; px++) step(1'b0, 1'b0, 1'b0, 1'b0, px, 0);
        check_val("pre_rst_green", int'(vif.green), BL);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_val("async_rst_red", int'(vif.red), 0);
        check_val("async_rst_green", int'(vif.green), 0);
        check_val("async_rst_blue", int'(vif.blue), 0);
        check_val("async_rst_hsync", int'(vif.hsync), 0);
        check_val("async_rst_vsync", int'(vif.vsync), 0);
        exp_q.delete();
        tag_q.delete();
        repeat (3) @(posedge clk_pixel);
        #2;
        check_val("held_rst_green", int'(vif.green), 0);
        check_val("held_rst_frame_start", int'(vif.frame_start), 0);
        model_reset();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive_vblank(2);
        fid = 6;                                   // first full frame after reset
        drive_line(800, 0, 1'b0, 1'b0);
        drive_vblank(1);

        for (int i = 0; i < vecs.size(); i++) begin
            int k;
            k = key_of(vecs[i].f, vecs[i].px, vecs[i].ln);
            checks++;
            if (!cap.exists(k)) begin
                errors++;
                $display("FAIL vec%0d f=%0d x=%0d y=%0d act=none exp=%h", i, vecs[i].f, vecs[i].px, vecs[i].ln, vecs[i].rgb);
            end else if (cap[k] !== vecs[i].rgb) begin
                errors++;
                $display("FAIL vec%0d f=%0d x=%0d y=%0d act=%h exp=%h", i, vecs[i].f, vecs[i].px, vecs[i].ln, cap[k], vecs[i].rgb);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
